// File: rtl/data_memory_responder_if.sv
// Request/response and debug-dump channel bundle for data_memory_responder.
// The slave side is the memory; the master side is the pipeline / debug unit.
interface data_memory_responder_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_we;
    logic [NB_ADDR-1:0] i_req_addr;
    logic [1:0]         i_req_width;
    logic               i_req_signed;
    logic [NB_DATA-1:0] i_req_wdata;
    logic               o_rsp_valid;
    logic [NB_DATA-1:0] o_rsp_rdata;
    logic               o_rsp_err;
    logic               i_dbg_start;
    logic               i_dbg_ready;
    logic               o_dbg_valid;
    logic [NB_ADDR-3:0] o_dbg_addr;
    logic [NB_DATA-1:0] o_dbg_data;
    logic               o_dbg_done;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_width, i_req_signed, i_req_wdata,
        input  i_dbg_start, i_dbg_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_dbg_valid, o_dbg_addr, o_dbg_data, o_dbg_done
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_width, i_req_signed, i_req_wdata,
        output i_dbg_start, i_dbg_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_dbg_valid, o_dbg_addr, o_dbg_data, o_dbg_done
    );
endinterface

// File: rtl/data_memory_responder.sv
// MIPS data memory: byte/half/word access with one-cycle registered response plus a debug dump port.
// Define DMEM_CLEAR_ON_RESET_EN to zero the whole memory (one word per cycle) after every reset.
module data_memory_responder #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic clk,
    input  logic i_rst_n,
    data_memory_responder_if.slave bus
);
    localparam int NB_IDX = NB_ADDR - 2;
    localparam int DEPTH  = 1 << NB_IDX;
    localparam logic [NB_IDX-1:0] IDX_ONE  = NB_IDX'(1);
    localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(DEPTH - 1);

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [1:0] ST_INIT = 2'd0;
`endif
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [1:0] ST_RESET = ST_INIT;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    logic [NB_DATA-1:0] mem [DEPTH];

    logic [1:0]         state;
    logic               rsp_valid;
    logic [NB_DATA-1:0] rsp_rdata;
    logic               rsp_err;
    logic               dbg_valid;
    logic [NB_IDX-1:0]  dbg_idx;
    logic [NB_DATA-1:0] dbg_data;
`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [NB_IDX-1:0]  init_idx;
`endif

    logic               accept;
    logic               req_err;
    logic               store_we;
    logic [NB_IDX-1:0]  req_idx;
    logic [1:0]         req_lane;
    logic [3:0]         wr_mask;
    logic [NB_DATA-1:0] wr_data;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] load_data;

    // Ready is gated by reset so it reads low while reset is held.
    assign bus.o_req_ready = i_rst_n && (state == ST_IDLE);
    assign accept   = bus.i_req_valid && bus.o_req_ready;
    assign req_idx  = bus.i_req_addr[NB_ADDR-1:2];
    assign req_lane = bus.i_req_addr[1:0];
    assign store_we = accept && bus.i_req_we && !req_err;

    always_comb begin
        req_err = 1'b0;
        case (bus.i_req_width)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.i_req_addr[0];
            2'b10:   req_err = |bus.i_req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the mask alone selects what lands.
    always_comb begin
        wr_mask = 4'b0000;
        wr_data = bus.i_req_wdata;
        case (bus.i_req_width)
            2'b00: begin
                wr_mask = 4'b0001 << req_lane;
                wr_data = {4{bus.i_req_wdata[7:0]}};
            end
            2'b01: begin
                wr_mask = bus.i_req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.i_req_wdata[15:0]}};
            end
            2'b10:   wr_mask = 4'b1111;
            default: wr_mask = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word   = mem[req_idx];
        rd_byte   = rd_word[{req_lane, 3'b000} +: 8];
        rd_half   = bus.i_req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (bus.i_req_width)
            2'b00:   load_data = bus.i_req_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   load_data = bus.i_req_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            2'b10:   load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Memory array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (i_rst_n && state == ST_INIT)
            mem[init_idx] <= '0;
        else
`endif
        if (store_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_mask[k])
                    mem[req_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state     <= ST_RESET;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            dbg_valid <= 1'b0;
            dbg_idx   <= '0;
            dbg_data  <= '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            init_idx  <= '0;
`endif
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && req_err;
            rsp_rdata <= (accept && !req_err && !bus.i_req_we) ? load_data : '0;
            case (state)
`ifdef DMEM_CLEAR_ON_RESET_EN
                ST_INIT: begin
                    init_idx <= init_idx + IDX_ONE;
                    if (init_idx == IDX_LAST)
                        state <= ST_IDLE;
                end
`endif
                ST_IDLE: begin
                    if (!bus.i_req_valid && bus.i_dbg_start) begin
                        state     <= ST_DUMP;
                        dbg_idx   <= '0;
                        dbg_valid <= 1'b0;
                    end
                end
                // Each word is fetched in the cycle after the previous one is consumed.
                ST_DUMP: begin
                    if (!dbg_valid) begin
                        dbg_valid <= 1'b1;
                        dbg_data  <= mem[dbg_idx];
                    end else if (bus.i_dbg_ready) begin
                        dbg_valid <= 1'b0;
                        if (dbg_idx == IDX_LAST) begin
                            state   <= ST_DONE;
                            dbg_idx <= '0;
                        end else begin
                            dbg_idx <= dbg_idx + IDX_ONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_rsp_rdata = rsp_rdata;
    assign bus.o_rsp_err   = rsp_err;
    assign bus.o_dbg_valid = dbg_valid;
    assign bus.o_dbg_addr  = dbg_idx;
    assign bus.o_dbg_data  = dbg_data;
    assign bus.o_dbg_done  = (state == ST_DONE);
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: byte-addressed reference memory, per-cycle response compare and a dump check.
// The clear-on-reset sequence is exercised when DMEM_CLEAR_ON_RESET_EN is defined.
module tb_data_memory_responder;
    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;
    localparam int DEPTH   = 1 << (NB_ADDR - 2);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic cmp_en = 1'b0;
    rsp_t exp_q[$];
    logic [7:0] model_b [DEPTH*4];

    data_memory_responder_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

    data_memory_responder #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference memory is a flat little-endian byte array.
    function automatic rsp_t modelAccess(input logic we, input int addr, input logic [1:0] width,
                                         input logic sgn, input logic [31:0] wdata);
        rsp_t r;
        int n;
        logic [31:0] v;
        n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : (width == 2'b10) ? 4 : 0;
        r.rdata = 32'h0;
        r.err   = (n == 0) || ((addr % n) != 0);
        if (r.err)
            return r;
        if (we) begin
            for (int i = 0; i < n; i++)
                model_b[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++)
                v[8*i +: 8] = model_b[addr + i];
            if (sgn && n < 4 && v[8*n - 1])
                v = v | (32'hFFFF_FFFF << (8 * n));
            r.rdata = v;
        end
        return r;
    endfunction

    function automatic logic [31:0] modelWord(input int idx);
        return {model_b[4*idx + 3], model_b[4*idx + 2], model_b[4*idx + 1], model_b[4*idx]};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            if (exp_q.size() > 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_valid", {31'h0, bus.o_rsp_valid}, 32'h1);
                checkOutput("rsp_rdata", bus.o_rsp_rdata, e.rdata);
                checkOutput("rsp_err", {31'h0, bus.o_rsp_err}, {31'h0, e.err});
            end else begin
                checkOutput("rsp_idle_valid", {31'h0, bus.o_rsp_valid}, 32'h0);
            end
        end
    end

    // Drives one request for one edge; returns #1 after that edge with the model updated.
    task automatic applyStimulus(input logic we, input int addr, input logic [1:0] width,
                                 input logic sgn, input logic [31:0] wdata);
        logic was_ready;
        @(negedge clk);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_addr   = addr[NB_ADDR-1:0];
        bus.i_req_width  = width;
        bus.i_req_signed = sgn;
        bus.i_req_wdata  = wdata;
        was_ready = bus.o_req_ready;
        checkOutput("req_ready", {31'h0, was_ready}, 32'h1);
        @(posedge clk);
        #1;
        if (was_ready)
            exp_q.push_back(modelAccess(we, addr, width, sgn, wdata));
    endtask

    task automatic pinReq(input string name, input logic we, input int addr, input logic [1:0] width,
                          input logic sgn, input logic [31:0] wdata,
                          input logic [31:0] lit_rdata, input logic lit_err);
        applyStimulus(we, addr, width, sgn, wdata);
        if (exp_q.size() > 0) begin
            checkOutput({name, "_model_rdata"}, exp_q[$].rdata, lit_rdata);
            checkOutput({name, "_model_err"}, {31'h0, exp_q[$].err}, {31'h0, lit_err});
        end
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({name, "_valid"}, {31'h0, bus.o_rsp_valid}, 32'h1);
        checkOutput({name, "_rdata"}, bus.o_rsp_rdata, lit_rdata);
        checkOutput({name, "_err"}, {31'h0, bus.o_rsp_err}, {31'h0, lit_err});
    endtask

    task automatic runDump();
        int exp_idx = 0;
        int done_cnt = 0;
        int cyc = 0;
        logic rdy;
        @(negedge clk);
        bus.i_dbg_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_dbg_start = 1'b0;
        while (done_cnt == 0 && cyc < 20 * DEPTH) begin
            @(negedge clk);
            checkOutput("dump_req_ready", {31'h0, bus.o_req_ready}, 32'h0);
            if (bus.o_dbg_done) begin
                done_cnt++;
                checkOutput("dump_words_before_done", exp_idx, DEPTH);
            end else if (bus.o_dbg_valid) begin
                checkOutput("dump_addr", {26'h0, bus.o_dbg_addr}, exp_idx);
                checkOutput("dump_data", bus.o_dbg_data, modelWord(exp_idx));
            end
            rdy = cyc[1];
            bus.i_dbg_ready = rdy;
            if (bus.o_dbg_valid && rdy)
                exp_idx++;
            cyc++;
        end
        checkOutput("dump_done_seen", done_cnt, 1);
        @(negedge clk);
        bus.i_dbg_ready = 1'b0;
        checkOutput("dump_done_pulse", {31'h0, bus.o_dbg_done}, 32'h0);
        checkOutput("dump_back_idle", {31'h0, bus.o_req_ready}, 32'h1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, {31'h0, bus.o_req_ready}, 32'h0);
        checkOutput({tag, "_rsp_valid"}, {31'h0, bus.o_rsp_valid}, 32'h0);
        checkOutput({tag, "_rsp_rdata"}, bus.o_rsp_rdata, 32'h0);
        checkOutput({tag, "_rsp_err"}, {31'h0, bus.o_rsp_err}, 32'h0);
        checkOutput({tag, "_dbg_valid"}, {31'h0, bus.o_dbg_valid}, 32'h0);
        checkOutput({tag, "_dbg_addr"}, {26'h0, bus.o_dbg_addr}, 32'h0);
        checkOutput({tag, "_dbg_data"}, bus.o_dbg_data, 32'h0);
        checkOutput({tag, "_dbg_done"}, {31'h0, bus.o_dbg_done}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_addr   = '0;
        bus.i_req_width  = 2'b00;
        bus.i_req_signed = 1'b0;
        bus.i_req_wdata  = '0;
        bus.i_dbg_start  = 1'b0;
        bus.i_dbg_ready  = 1'b0;
        for (int i = 0; i < DEPTH * 4; i++)
            model_b[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        #1;

`ifdef DMEM_CLEAR_ON_RESET_EN
        begin
            int cnt = 0;
            repeat (10) @(posedge clk);
            #1;
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            checkResetOutputs("init_abort");
            rst_n = 1'b1;
            #1;
            while (bus.o_req_ready == 1'b0 && cnt < 4 * DEPTH) begin
                cnt++;
                @(negedge clk);
                #1;
            end
            checkOutput("init_ready_low_cycles", cnt, DEPTH);
            cmp_en = 1'b1;
            for (int i = 0; i < DEPTH; i++)
                applyStimulus(1'b0, 4 * i, 2'b10, 1'b0, 32'h0);
            bus.i_req_valid = 1'b0;
        end
`else
        checkOutput("ready_after_reset", {31'h0, bus.o_req_ready}, 32'h1);
        cmp_en = 1'b1;
`endif

        // Fill every word so later reads and the dump have known contents.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 4 * i, 2'b10, 1'b0, 32'h9E37_79B1 * (i + 1));
        bus.i_req_valid = 1'b0;

        pinReq("st_word",     1'b1, 'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        pinReq("ld_word",     1'b0, 'h10, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 'h10, 2'b10, 1'b0, 32'h0);
        applyStimulus(1'b1, 'h11, 2'b00, 1'b0, 32'h0000_0080);
        pinReq("ld_byte_s",   1'b0, 'h11, 2'b00, 1'b1, 32'h0,         32'hFFFF_FF80, 1'b0);
        pinReq("ld_byte_u",   1'b0, 'h11, 2'b00, 1'b0, 32'h0,         32'h0000_0080, 1'b0);
        pinReq("ld_word_b",   1'b0, 'h10, 2'b10, 1'b0, 32'h0,         32'h0000_8000, 1'b0);
        applyStimulus(1'b1, 'h20, 2'b10, 1'b0, 32'h0);
        applyStimulus(1'b1, 'h22, 2'b01, 1'b0, 32'h0000_8001);
        pinReq("ld_half_s",   1'b0, 'h22, 2'b01, 1'b1, 32'h0,         32'hFFFF_8001, 1'b0);
        pinReq("ld_half_u",   1'b0, 'h22, 2'b01, 1'b0, 32'h0,         32'h0000_8001, 1'b0);
        pinReq("ld_word_h",   1'b0, 'h20, 2'b10, 1'b0, 32'h0,         32'h8001_0000, 1'b0);
        pinReq("err_ld_w13",  1'b0, 'h13, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b1);
        pinReq("err_st_h21",  1'b1, 'h21, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
        pinReq("err_w11_ld",  1'b0, 'h20, 2'b11, 1'b0, 32'h0,         32'h0000_0000, 1'b1);
        pinReq("err_w11_st",  1'b1, 'h20, 2'b11, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1);
        pinReq("ld_word_kept",1'b0, 'h20, 2'b10, 1'b0, 32'h0,         32'h8001_0000, 1'b0);

        // Back-to-back: stores with junk upper bits, loads immediately behind them.
        applyStimulus(1'b1, 'h30, 2'b10, 1'b0, 32'h0);
        applyStimulus(1'b1, 'h33, 2'b00, 1'b0, 32'hABCD_EF12);
        applyStimulus(1'b1, 'h30, 2'b01, 1'b0, 32'h1234_F00D);
        applyStimulus(1'b0, 'h30, 2'b10, 1'b0, 32'h0);
        applyStimulus(1'b0, 'h32, 2'b00, 1'b1, 32'h0);
        pinReq("ld_byte_pos", 1'b0, 'h33, 2'b00, 1'b1, 32'h0,         32'h0000_0012, 1'b0);
        pinReq("ld_half_lo",  1'b0, 'h30, 2'b01, 1'b0, 32'h0,         32'h0000_F00D, 1'b0);
        pinReq("ld_word_mix", 1'b0, 'h30, 2'b10, 1'b0, 32'h0,         32'h1200_F00D, 1'b0);

        // A request alongside dbg_start wins and the start is dropped.
        @(negedge clk);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = 1'b0;
        bus.i_req_addr   = 8'h10;
        bus.i_req_width  = 2'b10;
        bus.i_req_signed = 1'b0;
        bus.i_dbg_start  = 1'b1;
        checkOutput("start_req_ready", {31'h0, bus.o_req_ready}, 32'h1);
        @(posedge clk);
        #1;
        exp_q.push_back(modelAccess(1'b0, 'h10, 2'b10, 1'b0, 32'h0));
        bus.i_req_valid = 1'b0;
        bus.i_dbg_start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("start_ignored_ready", {31'h0, bus.o_req_ready}, 32'h1);
            checkOutput("start_ignored_dbg", {31'h0, bus.o_dbg_valid}, 32'h0);
        end

        runDump();
        applyStimulus(1'b0, 'h20, 2'b10, 1'b0, 32'h0);
        bus.i_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rsp_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
